// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready stream among NumReq requesters.
// Packets lock the grant until their last beat; the granted beat is held in one output register.
module stream_rr_arbiter #(
    parameter int unsigned NumReq    = 4,
    parameter int unsigned WordWidth = 64,
    parameter int unsigned IdWidth   = $clog2(NumReq)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NumReq-1:0]             req_vld_i,
    input  logic [NumReq*WordWidth-1:0]   req_payload_i,
    input  logic [NumReq-1:0]             req_last_i,
    output logic [NumReq-1:0]             req_rdy_o,
    output logic                          out_vld_o,
    output logic [WordWidth-1:0]          out_payload_o,
    output logic [IdWidth-1:0]            out_id_o,
    output logic                          out_last_o,
    input  logic                          out_rdy_i,
    input  logic                          flush_i
);

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    localparam logic [IdWidth-1:0] LastIdx = IdWidth'(NumReq - 1);

    lock_state_e            r_state,     w_state_nxt;
    logic [IdWidth-1:0]     r_ptr,       w_ptr_nxt;
    logic [IdWidth-1:0]     r_lock_id,   w_lock_id_nxt;
    logic                   r_vld,       w_vld_nxt;
    logic [WordWidth-1:0]   r_payload,   w_payload_nxt;
    logic [IdWidth-1:0]     r_id,        w_id_nxt;
    logic                   r_last,      w_last_nxt;

    logic                   w_load;
    logic                   w_found;
    logic                   w_accept;
    logic [IdWidth-1:0]     w_gnt;
    logic [NumReq-1:0]      w_cand;
    logic [NumReq-1:0]      w_rdy;
    int unsigned            w_scan;
    logic [WordWidth-1:0]   w_pay_arr [NumReq];

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
        assign w_pay_arr[gi] = req_payload_i[gi*WordWidth +: WordWidth];
    end

    // Register may take a new beat when empty or draining this cycle
    assign w_load = ~flush_i & (~r_vld | out_rdy_i);

    // While a packet is open only its owner competes
    always_comb begin
        w_cand = req_vld_i;
        if (r_state == ST_LOCKED) begin
            w_cand            = '0;
            w_cand[r_lock_id] = 1'b1;
        end
    end

    // First candidate at or after the pointer, wrapping modulo NumReq
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_scan  = 0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            w_scan = 32'(r_ptr) + k;
            if (w_scan >= NumReq) begin
                w_scan = w_scan - NumReq;
            end
            if (!w_found && w_cand[w_scan[IdWidth-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_scan[IdWidth-1:0];
            end
        end
    end

    always_comb begin
        w_rdy = '0;
        if (w_found && w_load) begin
            w_rdy[w_gnt] = req_vld_i[w_gnt];
        end
    end

    assign w_accept  = w_found & w_load & req_vld_i[w_gnt];
    assign req_rdy_o = w_rdy;

    // Next-state: flush beats accept, accept beats drain
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_lock_id_nxt = r_lock_id;
        w_vld_nxt     = r_vld;
        w_payload_nxt = r_payload;
        w_id_nxt      = r_id;
        w_last_nxt    = r_last;
        if (flush_i) begin
            w_vld_nxt   = 1'b0;
            w_state_nxt = ST_OPEN;
            w_ptr_nxt   = '0;
        end else if (w_accept) begin
            w_vld_nxt     = 1'b1;
            w_payload_nxt = w_pay_arr[w_gnt];
            w_id_nxt      = w_gnt;
            w_last_nxt    = req_last_i[w_gnt];
            if (req_last_i[w_gnt]) begin
                w_state_nxt = ST_OPEN;
                w_ptr_nxt   = (w_gnt == LastIdx) ? '0 : w_gnt + IdWidth'(1);
            end else begin
                w_state_nxt   = ST_LOCKED;
                w_lock_id_nxt = w_gnt;
            end
        end else if (out_rdy_i && r_vld) begin
            w_vld_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_OPEN;
            r_ptr     <= '0;
            r_lock_id <= '0;
            r_vld     <= 1'b0;
            r_payload <= '0;
            r_id      <= '0;
            r_last    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_lock_id <= w_lock_id_nxt;
            r_vld     <= w_vld_nxt;
            r_payload <= w_payload_nxt;
            r_id      <= w_id_nxt;
            r_last    <= w_last_nxt;
        end
    end

    assign out_vld_o     = r_vld;
    assign out_payload_o = r_payload;
    assign out_id_o      = r_id;
    assign out_last_o    = r_last;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: a 4-requester and a 3-requester instance driven with random
// packet traffic and compared every cycle against a queue-free priority-distance model.
module tb_stream_rr_arbiter;

    localparam int unsigned WW = 16;

    logic clk;
    logic rstn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus per instance (0: four requesters, 1: three requesters)
    bit            s_vld   [2][4];
    bit            s_last  [2][4];
    logic [WW-1:0] s_pay   [2][4];
    bit            s_ordy  [2];
    bit            s_flush [2];
    int            beats_left [2][4];

    logic [3:0]      vld4, last4, rdy4;
    logic [4*WW-1:0] pay4;
    logic            o_vld4, o_last4;
    logic [WW-1:0]   o_pay4;
    logic [1:0]      o_id4;

    logic [2:0]      vld3, last3, rdy3;
    logic [3*WW-1:0] pay3;
    logic            o_vld3, o_last3;
    logic [WW-1:0]   o_pay3;
    logic [1:0]      o_id3;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            vld4[i]            = s_vld[0][i];
            last4[i]           = s_last[0][i];
            pay4[i*WW +: WW]   = s_pay[0][i];
        end
        for (int i = 0; i < 3; i++) begin
            vld3[i]            = s_vld[1][i];
            last3[i]           = s_last[1][i];
            pay3[i*WW +: WW]   = s_pay[1][i];
        end
    end

    stream_rr_arbiter #(.NumReq(4), .WordWidth(WW)) u_dut4 (
        .clk           (clk),
        .rstn          (rstn),
        .req_vld_i     (vld4),
        .req_payload_i (pay4),
        .req_last_i    (last4),
        .req_rdy_o     (rdy4),
        .out_vld_o     (o_vld4),
        .out_payload_o (o_pay4),
        .out_id_o      (o_id4),
        .out_last_o    (o_last4),
        .out_rdy_i     (s_ordy[0]),
        .flush_i       (s_flush[0])
    );

    stream_rr_arbiter #(.NumReq(3), .WordWidth(WW)) u_dut3 (
        .clk           (clk),
        .rstn          (rstn),
        .req_vld_i     (vld3),
        .req_payload_i (pay3),
        .req_last_i    (last3),
        .req_rdy_o     (rdy3),
        .out_vld_o     (o_vld3),
        .out_payload_o (o_pay3),
        .out_id_o      (o_id3),
        .out_last_o    (o_last3),
        .out_rdy_i     (s_ordy[1]),
        .flush_i       (s_flush[1])
    );

    int n_cmp;
    int n_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit            m_vld     [2];
    logic [WW-1:0] m_pay     [2];
    int            m_id      [2];
    bit            m_last    [2];
    int            m_ptr     [2];
    bit            m_lock    [2];
    int            m_lock_id [2];
    int            m_acc     [2];

    function automatic int mdl_n(input int u);
        return (u == 0) ? 4 : 3;
    endfunction

    // Winner = eligible requester with smallest cyclic distance from the pointer
    function automatic int mdl_grant(input int u);
        int n     = mdl_n(u);
        int best  = -1;
        int bestd = n;
        for (int i = 0; i < n; i++) begin
            bit cand = m_lock[u] ? (i == m_lock_id[u]) : s_vld[u][i];
            int d    = (i - m_ptr[u] + n) % n;
            if (cand && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    function automatic bit mdl_load(input int u);
        return !s_flush[u] && (!m_vld[u] || s_ordy[u]);
    endfunction

    task automatic mdl_reset(input int u);
        m_vld[u] = 1'b0; m_pay[u] = '0; m_id[u] = 0; m_last[u] = 1'b0;
        m_ptr[u] = 0; m_lock[u] = 1'b0; m_lock_id[u] = 0; m_acc[u] = -1;
    endtask

    task automatic mdl_step(input int u);
        int g = mdl_grant(u);
        m_acc[u] = -1;
        if (s_flush[u]) begin
            m_vld[u]  = 1'b0;
            m_lock[u] = 1'b0;
            m_ptr[u]  = 0;
        end else if (g >= 0 && mdl_load(u) && s_vld[u][g]) begin
            m_acc[u]  = g;
            m_vld[u]  = 1'b1;
            m_pay[u]  = s_pay[u][g];
            m_id[u]   = g;
            m_last[u] = s_last[u][g];
            if (s_last[u][g]) begin
                m_lock[u] = 1'b0;
                m_ptr[u]  = (g + 1) % mdl_n(u);
            end else begin
                m_lock[u]    = 1'b1;
                m_lock_id[u] = g;
            end
        end else if (s_ordy[u] && m_vld[u]) begin
            m_vld[u] = 1'b0;
        end
    endtask

    task automatic check_inst(input int u);
        int         g  = mdl_grant(u);
        logic [3:0] er = '0;
        if (g >= 0 && mdl_load(u) && s_vld[u][g]) er[2'(g)] = 1'b1;
        if (u == 0) begin
            chk("n4.vld",     64'(o_vld4),  64'(m_vld[0]));
            chk("n4.payload", 64'(o_pay4),  64'(m_pay[0]));
            chk("n4.id",      64'(o_id4),   64'(m_id[0]));
            chk("n4.last",    64'(o_last4), 64'(m_last[0]));
            chk("n4.rdy",     64'(rdy4),    64'(er));
        end else begin
            chk("n3.vld",     64'(o_vld3),  64'(m_vld[1]));
            chk("n3.payload", 64'(o_pay3),  64'(m_pay[1]));
            chk("n3.id",      64'(o_id3),   64'(m_id[1]));
            chk("n3.last",    64'(o_last3), 64'(m_last[1]));
            chk("n3.rdy",     64'(rdy3),    64'(er[2:0]));
        end
    endtask

    // Requesters hold a presented beat until accepted, then maybe offer the next one
    task automatic gen(input int u);
        for (int i = 0; i < mdl_n(u); i++) begin
            if (m_acc[u] == i) begin
                beats_left[u][i]--;
                s_vld[u][i] = 1'b0;
            end
            if (!s_vld[u][i]) begin
                if (beats_left[u][i] == 0 && $urandom_range(2) == 0)
                    beats_left[u][i] = 1 + int'($urandom_range(2));
                if (beats_left[u][i] > 0 && $urandom_range(5) != 0) begin
                    s_vld[u][i]  = 1'b1;
                    s_pay[u][i]  = WW'($urandom);
                    s_last[u][i] = (beats_left[u][i] == 1);
                end
            end
        end
        s_ordy[u]  = ($urandom_range(9) < 7);
        s_flush[u] = ($urandom_range(39) == 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rstn  = 1'b0;
        for (int u = 0; u < 2; u++) begin
            mdl_reset(u);
            s_ordy[u]  = 1'b1;
            s_flush[u] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                s_vld[u][i] = 1'b0; s_last[u][i] = 1'b0; s_pay[u][i] = '0;
                beats_left[u][i] = 0;
            end
        end
        // Everyone valid with single-beat packets: strict 0,1,2,3 rotation
        for (int i = 0; i < 4; i++) begin
            s_vld[0][i]  = 1'b1;
            s_last[0][i] = 1'b1;
            s_pay[0][i]  = WW'(16 + i);
        end
        repeat (3) @(negedge clk);
        chk("reset.vld", 64'(o_vld4), 64'd0);
        chk("reset.id",  64'(o_id4),  64'd0);
        rstn = 1'b1;
        check_inst(0);
        check_inst(1);

        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            mdl_step(0); mdl_step(1);
            check_inst(0); check_inst(1);
            chk("fair.vld", 64'(o_vld4), 64'd1);
            chk("fair.id",  64'(o_id4),  64'((c - 1) % 4));
            chk("fair.pay", 64'(o_pay4), 64'(16 + (c - 1) % 4));
        end

        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            mdl_step(0); mdl_step(1);
            check_inst(0); check_inst(1);
            gen(0); gen(1);
            if (c == 700) begin
                // Asynchronous reset between edges must clear outputs immediately
                #2 rstn = 1'b0;
                #1;
                mdl_reset(0); mdl_reset(1);
                chk("areset.vld4", 64'(o_vld4), 64'd0);
                chk("areset.vld3", 64'(o_vld3), 64'd0);
                check_inst(0); check_inst(1);
                @(negedge clk);
                rstn = 1'b1;
                check_inst(0); check_inst(1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
